// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-add multiplier sequencer driving a shared adder; MUL_EARLY_TERM_EN skips RUN on zero operands
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_c0,
  input  logic [WIDTH-1:0] add_s
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic             cout, zero_op;
`ifdef MUL_EARLY_TERM_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif
  always_comb begin
    add_x  = state == RUN ? prod_hi : '0;
    add_y  = (state == RUN && prod_lo[0]) ? mcand : '0;
    add_c0 = 1'b0;
    cout   = (add_x[WIDTH-1] & add_y[WIDTH-1]) | ((add_x[WIDTH-1] ^ add_y[WIDTH-1]) & ~add_s[WIDTH-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
      mcand   <= '0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start && zero_op) begin
        prod_hi <= '0;
        prod_lo <= '0;
        done    <= 1'b1;
      end else if (start) begin
        prod_hi <= '0;
        prod_lo <= b;
        mcand   <= a;
        cnt     <= '0;
        state   <= RUN;
        busy    <= 1'b1;
      end
    end else begin
      // the adder has no carry-out, so it is rebuilt from the operand and sum MSBs
      {prod_hi, prod_lo} <= {cout, add_s, prod_lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed self-checking bench for mul_seq_ctrl with a behavioural adder
module tb_mul_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, add_c0;
  logic [31:0] prod_hi, prod_lo, add_x, add_y, add_s;
  int          checks = 0, errors = 0;
  int          lat, pulses;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo),
    .add_x(add_x), .add_y(add_y), .add_c0(add_c0), .add_s(add_s)
  );

  assign add_s = add_x + add_y + {31'd0, add_c0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!done && n < 100);
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    chk("rst_addx", 64'(add_x), 64'd0);
    chk("rst_addc0", 64'(add_c0), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 3 x 5
    go(32'd3, 32'd5);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_done0", 64'(done), 64'd0);
    chk("t1_addx", 64'(add_x), 64'd0);
    chk("t1_addy", 64'(add_y), 64'd3);
    wait_done(lat);
    chk("t1_lat", 64'(lat), 64'd32);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_prod", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);
    @(posedge clk);
    #1;
    chk("t1_pulse", 64'(done), 64'd0);
    chk("t1_hold", {prod_hi, prod_lo}, 64'h0000_0000_0000_000F);
    chk("t1_idle_addy", 64'(add_y), 64'd0);

    // all ones squared
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("t2_lat", 64'(lat), 64'd32);
    chk("t2_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);

    // start during RUN is ignored
    go(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(posedge clk);
    #1;
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    chk("t3_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("t3_lat", 64'(lat + 8), 64'd32);
    chk("t3_prod", {prod_hi, prod_lo}, 64'h0B00_EA4E_242D_2080);

    // asynchronous reset mid-RUN
    go(32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_prod", {prod_hi, prod_lo}, 64'd0);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    chk("t4_nodone", 64'(pulses), 64'd0);
    go(32'd7, 32'd9);
    wait_done(lat);
    chk("t4_lat", 64'(lat), 64'd32);
    chk("t4_prod", {prod_hi, prod_lo}, 64'h3F);

    // back-to-back: start held high through done
    @(negedge clk);
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat);
    chk("t5_lat1", 64'(lat), 64'd32);
    chk("t5_prod1", {prod_hi, prod_lo}, 64'd6);
    a = 32'd4;
    b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_done_drop", 64'(done), 64'd0);
    chk("t5_busy2", 64'(busy), 64'd1);
    chk("t5_load", {prod_hi, prod_lo}, 64'd5);
    wait_done(lat);
    chk("t5_lat2", 64'(lat), 64'd32);
    chk("t5_prod2", {prod_hi, prod_lo}, 64'h14);

    // zero multiplicand
    go(32'd0, 32'hDEAD_BEEF);
`ifdef MUL_EARLY_TERM_EN
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_prod", {prod_hi, prod_lo}, 64'd0);
    @(posedge clk);
    #1;
    chk("t6_pulse", 64'(done), 64'd0);
`else
    chk("t6_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("t6_lat", 64'(lat), 64'd32);
    chk("t6_prod", {prod_hi, prod_lo}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
